// File: rtl/riscv_pkg.sv
// Shared core types: memory-port arbiter state and owner encodings.
package riscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    localparam int unsigned REQ_IF = 0;
    localparam int unsigned REQ_LS = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and shared-memory bundle of the memory-port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    logic              ls_req_valid;
    logic              ls_req_we;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [BE_W-1:0]   ls_req_be;
    logic              ls_req_ready;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [BE_W-1:0]   mem_req_be;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              busy;

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_valid, ls_req_we, ls_req_addr,
        output ls_req_wdata, ls_req_be,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  busy
    );

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_valid, ls_req_we, ls_req_addr,
        input  ls_req_wdata, ls_req_be,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11): gnt = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction
// in flight at a time, with round-robin grant.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state;
    arb_state_t state_nxt;
    arb_owner_t owner;
    arb_owner_t last_grant;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       issue_vld;
    logic       rsp_fire;

    assign req = {bus.ls_req_valid, bus.if_req_valid};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue_vld = 1'b0;
        rsp_fire  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (|gnt) begin
                    accept    = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                issue_vld = 1'b1;
                if (bus.mem_req_ready) begin
                    rsp_fire  = bus.mem_rsp_valid;
                    state_nxt = bus.mem_rsp_valid ? ARB_IDLE
                                                  : ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    rsp_fire  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (gnt[REQ_LS]) begin
                    owner      <= OWN_LS;
                    last_grant <= OWN_LS;
                    lat_addr   <= bus.ls_req_addr;
                    lat_we     <= bus.ls_req_we;
                    lat_wdata  <= bus.ls_req_wdata;
                    lat_be     <= bus.ls_req_be;
                end else begin
                    owner      <= OWN_IF;
                    last_grant <= OWN_IF;
                    lat_addr   <= bus.if_req_addr;
                    lat_we     <= 1'b0;
                    lat_wdata  <= '0;
                    lat_be     <= '1;
                end
            end
        end
    end

    // Ready is combinational, so mask it while reset holds the FSM in IDLE.
    assign bus.if_req_ready = reset & accept & gnt[REQ_IF];
    assign bus.ls_req_ready = reset & accept & gnt[REQ_LS];

    assign bus.mem_req_valid = issue_vld;
    assign bus.mem_req_we    = issue_vld & lat_we;
    assign bus.mem_req_addr  = issue_vld ? lat_addr  : '0;
    assign bus.mem_req_wdata = issue_vld ? lat_wdata : '0;
    assign bus.mem_req_be    = issue_vld ? lat_be    : '0;

    assign bus.if_rsp_valid = rsp_fire & (owner == OWN_IF);
    assign bus.ls_rsp_valid = rsp_fire & (owner == OWN_LS);
    assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rsp_data : '0;
    assign bus.ls_rsp_data  = bus.ls_rsp_valid ? bus.mem_rsp_data : '0;

    assign bus.busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized check of mem_port_arbiter against a
// transaction-level model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct {
        bit          own_ls;
        logic [63:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   mode = 0;
    bit   mem_acc_q = 1'b0;
    bit   grants[$];

    bit   m_busy = 1'b0;
    bit   m_issued = 1'b0;
    bit   m_last_ls = 1'b1;
    txn_t cur;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) bus ();

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mode == 1) begin
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = mem_acc_q;
            bus.mem_rsp_data  = $urandom;
        end
    endtask

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin
        bit   g_if, g_ls, fire, ifv, lsv;
        if (!reset) begin
            chk("rst_if_ready", bus.if_req_ready, 0);
            chk("rst_ls_ready", bus.ls_req_ready, 0);
            chk("rst_if_rsp", bus.if_rsp_valid, 0);
            chk("rst_ls_rsp", bus.ls_rsp_valid, 0);
            chk("rst_if_data", bus.if_rsp_data, 0);
            chk("rst_ls_data", bus.ls_rsp_data, 0);
            chk("rst_mem_valid", bus.mem_req_valid, 0);
            chk("rst_mem_we", bus.mem_req_we, 0);
            chk("rst_mem_addr", bus.mem_req_addr, 0);
            chk("rst_mem_wdata", bus.mem_req_wdata, 0);
            chk("rst_mem_be", bus.mem_req_be, 0);
            chk("rst_busy", bus.busy, 0);
            m_busy    = 1'b0;
            m_issued  = 1'b0;
            m_last_ls = 1'b1;
            mem_acc_q = 1'b0;
        end else begin
            ifv  = bus.if_req_valid;
            lsv  = bus.ls_req_valid;
            g_if = !m_busy && ifv && (!lsv || m_last_ls);
            g_ls = !m_busy && lsv && (!ifv || !m_last_ls);
            fire = m_busy && (m_issued || bus.mem_req_ready)
                   && bus.mem_rsp_valid;
            chk("if_ready", bus.if_req_ready, g_if);
            chk("ls_ready", bus.ls_req_ready, g_ls);
            chk("busy", bus.busy, m_busy);
            chk("mem_valid", bus.mem_req_valid, m_busy && !m_issued);
            if (m_busy && !m_issued) begin
                chk("mem_addr", bus.mem_req_addr, cur.addr);
                chk("mem_we", bus.mem_req_we, cur.we);
                chk("mem_be", bus.mem_req_be, cur.be);
                if (cur.we)
                    chk("mem_wdata", bus.mem_req_wdata, cur.wdata);
            end
            chk("if_rsp", bus.if_rsp_valid, fire && !cur.own_ls);
            chk("ls_rsp", bus.ls_rsp_valid, fire && cur.own_ls);
            if (fire && !cur.own_ls)
                chk("if_data", bus.if_rsp_data, bus.mem_rsp_data);
            if (fire && cur.own_ls && !cur.we)
                chk("ls_data", bus.ls_rsp_data, bus.mem_rsp_data);
            if (m_busy && cur.own_ls)
                chk("if_data_idle", bus.if_rsp_data, 0);
            if (m_busy && !cur.own_ls)
                chk("ls_data_idle", bus.ls_rsp_data, 0);
            if (bus.if_req_ready) grants.push_back(1'b0);
            if (bus.ls_req_ready) grants.push_back(1'b1);
            mem_acc_q = bus.mem_req_valid && bus.mem_req_ready;
            if (g_if || g_ls) begin
                m_busy     = 1'b1;
                m_issued   = 1'b0;
                m_last_ls  = g_ls;
                cur.own_ls = g_ls;
                cur.addr   = g_ls ? bus.ls_req_addr : bus.if_req_addr;
                cur.we     = g_ls ? bus.ls_req_we : 1'b0;
                cur.wdata  = bus.ls_req_wdata;
                cur.be     = g_ls ? bus.ls_req_be : 4'hF;
            end else if (fire) begin
                m_busy = 1'b0;
            end else if (m_busy && !m_issued && bus.mem_req_ready) begin
                m_issued = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = '0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_req_we     = 1'b0;
        bus.ls_req_addr   = '0;
        bus.ls_req_wdata  = '0;
        bus.ls_req_be     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        #1 reset = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("lit_rst_busy", bus.busy, 0);
        chk("lit_rst_ready", bus.if_req_ready, 0);
        step();
        reset = 1'b1;

        // First fetch, memory answers in the issue cycle.
        @(negedge clk);
        chk("lit_acc_if", bus.if_req_ready, 1);
        chk("lit_acc_ls", bus.ls_req_ready, 0);
        step();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0013;
        @(negedge clk);
        chk("lit_mem_valid", bus.mem_req_valid, 1);
        chk("lit_mem_addr", bus.mem_req_addr, 0);
        chk("lit_mem_be", bus.mem_req_be, 4'hF);
        chk("lit_mem_we", bus.mem_req_we, 0);
        chk("lit_if_rsp", bus.if_rsp_valid, 1);
        chk("lit_if_data", bus.if_rsp_data, 32'h13);
        chk("lit_ls_rsp0", bus.ls_rsp_valid, 0);
        step();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.ls_req_valid  = 1'b1;
        bus.ls_req_we     = 1'b1;
        bus.ls_req_addr   = 64'h200;
        bus.ls_req_wdata  = 32'hDEAD_BEEF;
        bus.ls_req_be     = 4'hF;
        @(negedge clk);
        chk("lit_if_rsp_end", bus.if_rsp_valid, 0);
        chk("lit_busy_low", bus.busy, 0);
        chk("lit_next_acc", bus.ls_req_ready, 1);

        // Store held off by memory for three cycles.
        step();
        bus.ls_req_valid = 1'b0;
        bus.ls_req_addr  = 64'h0;
        bus.ls_req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_st_valid", bus.mem_req_valid, 1);
            chk("lit_st_addr", bus.mem_req_addr, 64'h200);
            chk("lit_st_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
            chk("lit_st_be", bus.mem_req_be, 4'hF);
            chk("lit_st_we", bus.mem_req_we, 1);
            step();
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("lit_st_wait", bus.ls_rsp_valid, 0);
        chk("lit_st_busy", bus.busy, 1);
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        chk("lit_st_rsp", bus.ls_rsp_valid, 1);
        chk("lit_st_if_rsp", bus.if_rsp_valid, 0);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("lit_st_once", bus.ls_rsp_valid, 0);

        // Both requesters held valid with a two-cycle memory.
        step();
        grants.delete();
        mode = 1;
        bus.mem_req_ready = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h4;
        bus.ls_req_valid  = 1'b1;
        bus.ls_req_we     = 1'b0;
        bus.ls_req_addr   = 64'h100;
        repeat (14) step();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        repeat (4) step();
        mode = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        chk("lit_grant_cnt", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            chk("lit_grant0", grants[0], 0);
            chk("lit_grant1", grants[1], 1);
            chk("lit_grant2", grants[2], 0);
            chk("lit_grant3", grants[3], 1);
            for (int i = 1; i < grants.size(); i++)
                chk("lit_alternate", grants[i] != grants[i-1], 1);
        end

        // Reset while waiting for a response, then a stray response.
        step();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 64'h8;
        step();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("lit_wait_busy", bus.busy, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("lit_mid_rst_busy", bus.busy, 0);
        step();
        reset = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("lit_stray_if", bus.if_rsp_valid, 0);
        chk("lit_stray_ls", bus.ls_rsp_valid, 0);
        chk("lit_stray_busy", bus.busy, 0);
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("lit_idle_kept", bus.busy, 0);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
            bus.if_req_valid  = ($urandom_range(0, 9) < 6);
            bus.if_req_addr   = {$urandom, $urandom};
            bus.ls_req_valid  = ($urandom_range(0, 9) < 6);
            bus.ls_req_we     = $urandom_range(0, 1);
            bus.ls_req_addr   = {$urandom, $urandom};
            bus.ls_req_wdata  = $urandom;
            bus.ls_req_be     = $urandom_range(0, 15);
            bus.mem_req_ready = ($urandom_range(0, 1) == 1);
            bus.mem_rsp_valid = ($urandom_range(0, 9) < 4);
            bus.mem_rsp_data  = $urandom;
        end
        step();
        reset = 1'b1;
        bus.if_req_valid  = 1'b0;
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
